mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 3, meaning the number of cycles from request acceptance to completion (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the reset; asynchronous and active-low.
REQ-005 SHALL have port mem_read, input, 1 bit, meaning the load request from the MEM stage.
REQ-006 SHALL have port mem_write, input, 1 bit, meaning the store request from the MEM stage.
REQ-007 SHALL have port adr, input, 32 bits, meaning the byte address; word index is adr[31:2].
REQ-008 SHALL have port write_data, input, 32 bits, meaning the store data.
REQ-009 SHALL have port read_data, output, 32 bits, meaning the registered load result.
REQ-010 SHALL have port mem_stall, output, 1 bit, meaning freeze PC, IF/ID, ID/EX and EX/M while high.
REQ-011 SHALL have port done, output, 1 bit, meaning a one-cycle pulse marking access completion.
REQ-012 SHALL have port err, output, 1 bit, meaning the completing access was illegal; valid only while done is high.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL treat req = mem_read | mem_write; in IDLE, req moves the FSM to BUSY and loads the latency counter with LATENCY-1; if LATENCY=1, IDLE goes directly to DONE.
REQ-015 SHALL decrement the counter in BUSY and go to DONE on the edge where the counter equals 1.
REQ-016 SHALL leave DONE for IDLE unconditionally after exactly one cycle.
REQ-017 SHALL drive mem_stall = (IDLE & req) | BUSY, combinationally; mem_stall is low in DONE.
REQ-018 SHALL sample request, adr and write_data on the edge that enters DONE; the MEM stage holds them stable while mem_stall is high.
REQ-019 SHALL complete a request accepted at cycle 0 with done high in cycle LATENCY, and mem_stall high in cycles 0..LATENCY-1.
REQ-020 SHALL perform a store on the edge entering DONE; read_data is unchanged by a store.
REQ-021 SHALL register mem[adr[31:2]] into read_data on the edge entering DONE for a load; read_data holds until the next load completes.
REQ-022 SHALL treat mem_read and mem_write both high as a store.
REQ-023 SHALL, for word index >= WORDS, drop the store, return 0 for a load, and set err in DONE.
REQ-024 SHALL accept a new request in the cycle after DONE (back-to-back accesses cost LATENCY+1 cycles each).
REQ-025 SHALL ignore request changes while in BUSY.

Reset
REQ-026 SHALL on rst_n low force the FSM to IDLE, counter to 0, read_data to 0, done to 0 and err to 0, regardless of state.
REQ-027 SHALL abort an in-flight access on reset without writing storage; storage contents are not reset.
REQ-028 SHALL still drive mem_stall high during reset if req is high, because of REQ-017.

Configuration
REQ-029 SHALL honour macro MEM_RESP_ALIGN_CHECK_EN.
REQ-030 SHALL, with MEM_RESP_ALIGN_CHECK_EN defined, treat adr[1:0] != 0 as illegal with REQ-023 behaviour.
REQ-031 SHALL, without MEM_RESP_ALIGN_CHECK_EN, ignore adr[1:0] and compute err from range only.

Structure
REQ-032 SHALL take the state encoding (IDLE=0, BUSY=1, DONE=2) and the default LATENCY/WORDS constants from the shared processor package.
REQ-033 SHALL place the storage array in one sub-module, mem_resp_array, with one write port and one read port.

Verification
REQ-034 SHALL cover: reset, then store 0xDEADBEEF at adr 0x10 with LATENCY=3 -> stall high for 3 cycles, done in cycle 3, err=0.
REQ-035 SHALL cover: load adr 0x10 after REQ-034 -> read_data=0xDEADBEEF in cycle 3, stall low in cycle 3.
REQ-036 SHALL cover: load adr 0x400 with WORDS=256 -> read_data=0, err=1, storage unchanged.
REQ-037 SHALL cover: rst_n low in cycle 1 of a store of 0x12345678 at 0x20 -> FSM IDLE, done never pulses, a later load of 0x20 returns the prior value.
REQ-038 SHALL cover: load adr 0x13 -> err=1 with MEM_RESP_ALIGN_CHECK_EN defined, and err=0 with read_data equal to mem[4] without it.
REQ-039 SHALL cover: LATENCY=1 with back-to-back loads -> each done in the cycle after acceptance, one IDLE cycle between accesses.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM encoding for the MEM-stage memory responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWords   = 256;
    localparam int unsigned DefaultLatency = 3;
    localparam int unsigned CntW           = 4;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the memory responder: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module mem_resp_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORDS = DefaultWords,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Guards non-power-of-two depths where the index can exceed the array.
    assign rdata = (32'(raddr) < WORDS) ? mem[raddr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data memory responder with stall/done handshake for the MEM stage.
// Optional macro MEM_RESP_ALIGN_CHECK_EN: misaligned addresses are illegal accesses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORDS   = DefaultWords,
    parameter int unsigned LATENCY = DefaultLatency
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        done,
    output logic        err
);

    localparam int unsigned     AddrW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0]     WordsW  = 32'(WORDS);
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     read_data_q;
    logic            err_q;
    logic            req;
    logic            enter_done;
    logic            in_range;
    logic            legal;
    logic            store_en;
    logic [31:0]     rdata_arr;

    assign req      = mem_read | mem_write;
    assign in_range = {2'b00, adr[31:2]} < WordsW;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign legal = in_range && (adr[1:0] == 2'b00);
`else
    logic [1:0] unused_byte_ofs;
    assign unused_byte_ofs = adr[1:0];
    assign legal           = in_range;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // rst_n gate keeps a LATENCY=1 store from landing while reset is held.
    assign store_en = enter_done & mem_write & legal & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= enter_done & ~legal;
            if (enter_done && mem_read && !mem_write) begin
                read_data_q <= legal ? rdata_arr : '0;
            end
        end
    end

    mem_resp_array #(
        .WORDS (WORDS),
        .AddrW (AddrW)
    ) u_array (
        .clk   (clk),
        .we    (store_en),
        .waddr (adr[AddrW+1:2]),
        .wdata (write_data),
        .raddr (adr[AddrW+1:2]),
        .rdata (rdata_arr)
    );

    assign mem_stall = ((state_q == StIdle) & req) | (state_q == StBusy);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, reset abort, random
// traffic against a word-level model, and LATENCY=1 back-to-back loads.
module tb_mem_responder;

    localparam int unsigned Lat   = 3;
    localparam int unsigned Words = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] adr, write_data, read_data;
    logic        mem_stall, done, err;
    logic        r1, w1;
    logic [31:0] a1, d1, rd1;
    logic        st1, dn1, er1;

    mem_responder #(.WORDS(Words), .LATENCY(Lat)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .adr        (adr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_stall  (mem_stall),
        .done       (done),
        .err        (err)
    );

    mem_responder #(.WORDS(Words), .LATENCY(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (r1),
        .mem_write  (w1),
        .adr        (a1),
        .write_data (d1),
        .read_data  (rd1),
        .mem_stall  (st1),
        .done       (dn1),
        .err        (er1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_mem   [Words];
    bit          m_known [Words];
    logic [31:0] m_rd;
    bit          m_rd_known;

    vec_t vecs [13];
    vec_t b2b  [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Word-level memory model: legality, store effect, and last-load result.
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] e_rd,
                                  output logic e_err, output bit e_known);
        int unsigned idx;
        bit          legal;
        idx   = a[31:2];
        legal = (idx < Words);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) legal = 1'b0;
`endif
        if (wr) begin
            if (legal) begin
                m_mem[idx]   = d;
                m_known[idx] = 1'b1;
            end
        end else if (rd) begin
            if (legal) begin
                m_rd       = m_mem[idx];
                m_rd_known = m_known[idx];
            end else begin
                m_rd       = '0;
                m_rd_known = 1'b1;
            end
        end
        e_rd    = m_rd;
        e_err   = !legal;
        e_known = m_rd_known;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          output logic [31:0] got_rd, output logic got_err,
                          output int got_cycle, output bit stall_ok);
        got_rd    = 'x;
        got_err   = 1'bx;
        got_cycle = -1;
        stall_ok  = 1'b1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; adr = a; write_data = d;
        for (int k = 0; k <= 20 && got_cycle < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (scramble && k >= 1 && k <= int'(Lat) - 2) begin
                mem_read = 1'($urandom); mem_write = 1'($urandom);
                adr = $urandom; write_data = $urandom;
            end else if (scramble && k >= 1 && k == int'(Lat) - 1) begin
                mem_read = rd; mem_write = wr; adr = a; write_data = d;
            end
            #1;
            if (done) begin
                got_cycle = k;
                got_rd    = read_data;
                got_err   = err;
                if (mem_stall) stall_ok = 1'b0;
            end else if (!mem_stall) begin
                stall_ok = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run_op(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input bit scramble,
                          input logic [31:0] exp_rd, input logic exp_err, input bit rd_known);
        logic [31:0] got_rd;
        logic        got_err;
        int          got_cycle;
        bit          stall_ok;
        access(rd, wr, a, d, scramble, got_rd, got_err, got_cycle, stall_ok);
        check({name, ".done_cycle"}, 32'(got_cycle), Lat);
        check({name, ".stall"}, {31'b0, stall_ok}, 32'd1);
        check({name, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
        if (rd_known) check({name, ".rdata"}, got_rd, exp_rd);
    endtask

    task automatic modeled_op(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d, input bit scramble);
        logic [31:0] e_rd;
        logic        e_err;
        bit          e_kn;
        model(rd, wr, a, d, e_rd, e_err, e_kn);
        run_op(name, rd, wr, a, d, scramble, e_rd, e_err, e_kn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e_rd;
        logic        e_err;
        bit          e_kn;
        int          dones;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'h0102_0304, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
`ifdef MEM_RESP_ALIGN_CHECK_EN
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
`else
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
`endif
        vecs[12] = '{1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};

        b2b[0] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 32'h0000_0000, 1'b0};
        b2b[1] = '{1'b0, 1'b1, 32'h0000_000C, 32'h2468_ACE0, 32'h0000_0000, 1'b0};
        b2b[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1357_9BDF, 1'b0};
        b2b[3] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h2468_ACE0, 1'b0};
        b2b[4] = '{1'b1, 1'b0, 32'h0000_0800, 32'h0,         32'h0000_0000, 1'b1};

        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; adr = '0; write_data = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
        m_rd = '0; m_rd_known = 1'b1;
        for (int i = 0; i < int'(Words); i++) m_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset.read_data", read_data, 32'h0);
        check("reset.done", {31'b0, done}, 32'h0);
        check("reset.err", {31'b0, err}, 32'h0);
        check("reset.stall", {31'b0, mem_stall}, 32'h0);
        check("reset.read_data_l1", rd1, 32'h0);
        rst_n = 1'b1;

        // Directed table: expected values are the table constants.
        for (int i = 0; i < 13; i++) begin
            model(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, e_rd, e_err, e_kn);
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                   1'b0, vecs[i].exp_rd, vecs[i].exp_err, 1'b1);
        end

        // Reset in cycle 1 of a store must abort it without touching storage.
        modeled_op("pre_store", 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0);
        modeled_op("pre_load", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        @(negedge clk);
        mem_write = 1'b1; adr = 32'h20; write_data = 32'h1234_5678;
        #1;
        check("rst.stall_c0", {31'b0, mem_stall}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.read_data", read_data, 32'h0);
        check("rst.err", {31'b0, err}, 32'h0);
        check("rst.done", {31'b0, done}, 32'h0);
        check("rst.stall_req", {31'b0, mem_stall}, 32'h1);
        dones = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        mem_write = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        check("rst.no_done", 32'(dones), 32'h0);
        m_rd = '0; m_rd_known = 1'b1;
        modeled_op("post_rst_load", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            modeled_op($sformatf("init%0d", i), 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic        rd, wr;
            int          sel, rw;
            sel = $urandom_range(0, 9);
            rw  = $urandom_range(0, 2);
            if (sel <= 6)      a = 32'($urandom_range(0, 31)) << 2;
            else if (sel == 7) a = $urandom | 32'h0000_0400;
            else if (sel == 8) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else               a = 32'h3FC;
            rd = (rw != 1);
            wr = (rw != 0);
            modeled_op($sformatf("rnd%0d", n), rd, wr, a, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LATENCY=1: request held high, DONE followed by an IDLE accept cycle.
        @(negedge clk);
        r1 = b2b[0].rd; w1 = b2b[0].wr; a1 = b2b[0].a; d1 = b2b[0].d;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("b2b%0d.accept_stall", i), {31'b0, st1}, 32'h1);
            check($sformatf("b2b%0d.accept_done", i), {31'b0, dn1}, 32'h0);
            @(negedge clk); #1;
            check($sformatf("b2b%0d.done", i), {31'b0, dn1}, 32'h1);
            check($sformatf("b2b%0d.done_stall", i), {31'b0, st1}, 32'h0);
            check($sformatf("b2b%0d.err", i), {31'b0, er1}, {31'b0, b2b[i].exp_err});
            check($sformatf("b2b%0d.rdata", i), rd1, b2b[i].exp_rd);
            if (i < 4) begin
                r1 = b2b[i+1].rd; w1 = b2b[i+1].wr; a1 = b2b[i+1].a; d1 = b2b[i+1].d;
            end else begin
                r1 = 1'b0; w1 = 1'b0;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
